// File: rtl/vlx_byte_writer_pkg.sv
// Shared types and helpers for the VLX byte writer slice.
package vlx_pkg;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_REQ  = 1'b1
  } wstate_e;

  localparam logic [1:0] CFG_BASE = 2'd0;
  localparam logic [1:0] CFG_PTR  = 2'd1;
  localparam logic [1:0] CFG_CNT  = 2'd2;
  localparam logic [1:0] CFG_CTRL = 2'd3;

  // Lane select with the n leading (most significant) bytes enabled.
  function automatic logic [3:0] sel_mask(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd1:    m = 4'b1000;
      3'd2:    m = 4'b1100;
      3'd3:    m = 4'b1110;
      3'd4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vlx_wb_word_writer.sv
// Holding register plus single-beat Wishbone write master.
module vlx_wb_word_writer
  import vlx_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [31:0]       load_dat_i,
  input  logic [3:0]        load_sel_i,
  input  logic [ADDR_W-1:0] ptr_i,
  output logic              hold_full_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  wstate_e           state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [31:0]       hold_dat_q, hold_dat_d;
  logic [3:0]        hold_sel_q, hold_sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              in_req;

  // State register; async reset drops cyc/stb immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= W_IDLE;
    else       state_q <= state_d;
  end

  // Next state: start when a word is held, finish on ack or err.
  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:  if (hold_full_q) state_d = W_REQ;
      W_REQ:   if (wb_ack_i || wb_err_i) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Bus outputs and completion strobes decoded from state.
  always_comb begin
    in_req   = (state_q == W_REQ);
    wb_cyc_o = in_req;
    wb_stb_o = in_req;
    wb_we_o  = in_req;
    wb_adr_o = adr_q;
    wb_dat_o = hold_dat_q;
    wb_sel_o = hold_sel_q;
    done_o   = in_req & (wb_ack_i | wb_err_i);
    err_o    = in_req & wb_err_i;
    hold_full_o = hold_full_q;
  end

  // Holding register and latched address: freed on completion, refilled on load.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_dat_d  = hold_dat_q;
    hold_sel_d  = hold_sel_q;
    adr_d       = adr_q;
    if (done_o) hold_full_d = 1'b0;
    if (load_i && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_dat_d  = load_dat_i;
      hold_sel_d  = load_sel_i;
    end
    if (state_q == W_IDLE && hold_full_q) adr_d = ptr_i;
  end

  // Holding / address flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_full_q <= 1'b0;
      hold_dat_q  <= '0;
      hold_sel_q  <= '0;
      adr_q       <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_dat_q  <= hold_dat_d;
      hold_sel_q  <= hold_sel_d;
      adr_q       <= adr_d;
    end
  end

endmodule

// File: rtl/vlx_byte_writer.sv
// Byte accept/pack front end and config registers of the VLX byte writer.
module vlx_byte_writer
  import vlx_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [7:0]  FLUSH_FILL = 8'h00
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ack_o,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_addr_i,
  input  logic [31:0]       cfg_dat_i,
  output logic [31:0]       cfg_dat_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  logic [31:0]       pack_q, pack_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       total_q, total_d;
  logic              err_q, err_d;
  logic              flush_q, flush_d;

  logic              accept, handoff;
  logic [31:0]       pack_a;
  logic [2:0]        cnt_a;
  logic [31:0]       ld_dat;
  logic [3:0]        ld_sel;
  logic              hold_full, wr_done, wr_err;
  logic [31:0]       ptr_rd;

  vlx_wb_word_writer #(.ADDR_W(ADDR_W)) u_wr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (handoff),
    .load_dat_i  (ld_dat),
    .load_sel_i  (ld_sel),
    .ptr_i       (ptr_q),
    .hold_full_o (hold_full),
    .done_o      (wr_done),
    .err_o       (wr_err),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  // Accept, pack, hand-off and config-register next-state logic.
  always_comb begin
    // cnt reaches 4 when a full word waits for the holding register.
    accept = byte_valid_i & ~ack_q & ~flush_q & (cnt_q != 3'd4);
    pack_a = pack_q;
    cnt_a  = cnt_q;
    if (accept) begin
      case (cnt_q)
        3'd0:    pack_a[31:24] = byte_i;
        3'd1:    pack_a[23:16] = byte_i;
        3'd2:    pack_a[15:8]  = byte_i;
        default: pack_a[7:0]   = byte_i;
      endcase
      cnt_a = cnt_q + 3'd1;
    end

    handoff = ~hold_full & ((cnt_a == 3'd4) | (flush_q & (cnt_a != 3'd0)));
    ld_sel  = sel_mask(cnt_a);
    ld_dat  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ld_dat[31-8*i -: 8] = ld_sel[3-i] ? pack_a[31-8*i -: 8] : FLUSH_FILL;
    end

    cnt_d  = handoff ? 3'd0 : cnt_a;
    pack_d = handoff ? '0 : pack_a;
    ack_d  = accept;

    flush_d = flush_q;
    if (flush_q && (cnt_a == 3'd0 || handoff)) flush_d = 1'b0;
    if (cfg_we_i && cfg_addr_i == CFG_CTRL && cfg_dat_i[0]) flush_d = 1'b1;

    err_d = err_q;
    if (cfg_we_i && cfg_addr_i == CFG_CTRL && cfg_dat_i[1]) err_d = 1'b0;
    if (wr_err) err_d = 1'b1;

    ptr_d = ptr_q;
    if (wr_done) ptr_d = ptr_q + ADDR_W'(4);
    if (cfg_we_i && cfg_addr_i == CFG_BASE) ptr_d = {cfg_dat_i[ADDR_W-1:2], 2'b00};

    total_d = total_q;
    if (accept) total_d = total_q + 32'd1;
    if (cfg_we_i && cfg_addr_i == CFG_CNT) total_d = '0;
  end

  // Front-end and config flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pack_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      ptr_q   <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      total_q <= total_d;
      err_q   <= err_d;
      flush_q <= flush_d;
    end
  end

  // Status outputs and combinational config readback.
  always_comb begin
    byte_ack_o = ack_q;
    busy_o     = (cnt_q != 3'd0) | hold_full | flush_q | wb_cyc_o;
    ptr_rd     = '0;
    ptr_rd[ADDR_W-1:0] = ptr_q;
    case (cfg_addr_i)
      CFG_BASE: cfg_dat_o = ptr_rd;
      CFG_PTR:  cfg_dat_o = ptr_rd;
      CFG_CNT:  cfg_dat_o = total_q;
      default:  cfg_dat_o = {29'd0, busy_o, err_q, flush_q};
    endcase
  end

endmodule

// File: tb/tb_vlx_byte_writer.sv
// Directed self-checking bench for vlx_byte_writer.
module tb_vlx_byte_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ack_o;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_dat_i;
  logic [31:0] cfg_dat_o;
  logic        busy_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i, wb_err_i;

  vlx_byte_writer #(.ADDR_W(32), .FLUSH_FILL(8'hA5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ack_o(byte_ack_o),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_dat_i(cfg_dat_i),
    .cfg_dat_o(cfg_dat_o), .busy_o(busy_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;
  int acks  = 0;
  int dbl   = 0;
  int ack_dly = 2;
  bit err_next = 1'b0;
  logic [7:0]  src_q[$];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic [3:0]  log_sel[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packer model: holds valid, advances to the next byte on each ack pulse.
  initial begin
    bit prev = 1'b0;
    byte_valid_i = 1'b0;
    byte_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (byte_ack_o) begin
        acks++;
        if (prev) dbl++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      prev = byte_ack_o;
      byte_valid_i = (src_q.size() > 0);
      byte_i = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  // Wishbone slave: ack (or err) after ack_dly cycles, log acked writes.
  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    forever begin
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
        repeat (ack_dly) @(negedge clk_i);
        if (wb_cyc_o) begin
          if (err_next) begin
            wb_err_i = 1'b1;
            err_next = 1'b0;
          end else begin
            log_adr.push_back(wb_adr_o);
            log_dat.push_back(wb_dat_o);
            log_sel.push_back(wb_sel_o);
            wb_ack_i = 1'b1;
          end
          @(negedge clk_i);
          wb_ack_i = 1'b0;
          wb_err_i = 1'b0;
          chk("cyc_drop_after_ack", {31'd0, wb_cyc_o}, 32'd0);
        end
      end
    end
  end

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_dat_i = d;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    #2;
  endtask

  task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr_i = a;
    #1 d = cfg_dat_o;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin
      @(negedge clk_i); #2; k++;
    end while ((src_q.size() > 0 || busy_o) && k < 400);
    if (k >= 400) chk({"timeout_", tag}, 32'd1, 32'd0);
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    do begin
      @(negedge clk_i); #2; k++;
    end while (!wb_ack_i && k < 200);
    if (k >= 200) chk({"timeout_", tag}, 32'd1, 32'd0);
  endtask

  task automatic chk_wr(input int idx, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    if (idx < log_adr.size()) begin
      chk($sformatf("wr%0d_adr", idx), log_adr[idx], adr);
      chk($sformatf("wr%0d_dat", idx), log_dat[idx], dat);
      chk($sformatf("wr%0d_sel", idx), {28'd0, log_sel[idx]}, {28'd0, sel});
    end else begin
      chk($sformatf("wr%0d_missing", idx), log_adr.size(), idx + 1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int a0, nw, k;
    cfg_we_i = 1'b0; cfg_addr_i = 2'd0; cfg_dat_i = '0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #2;
    // Reset state
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    cfg_rd(2'd1, rd); chk("rst_ptr", rd, 32'd0);
    cfg_rd(2'd2, rd); chk("rst_cnt", rd, 32'd0);
    cfg_rd(2'd3, rd); chk("rst_ctrl", rd, 32'd0);
    rst_i = 1'b0;

    // Two full words at base 0x1000
    cfg_wr(2'd0, 32'h0000_1003);
    cfg_rd(2'd1, rd); chk("base_aligned", rd, 32'h1000);
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    wait_idle("stream8");
    chk_wr(0, 32'h1000, 32'h0102_0304, 4'hF);
    chk_wr(1, 32'h1004, 32'h0506_0708, 4'hF);
    cfg_rd(2'd1, rd); chk("ptr_after8", rd, 32'h1008);
    cfg_rd(2'd2, rd); chk("cnt_after8", rd, 32'd8);
    chk("acks_after8", acks, 8);
    chk("no_double_ack", dbl, 0);

    // Partial word flush with fill lane
    src_q.push_back(8'hFF); src_q.push_back(8'h00); src_q.push_back(8'hAB);
    k = 0;
    while (src_q.size() > 0 && k < 100) begin @(negedge clk_i); k++; end
    repeat (2) @(negedge clk_i);
    #2;
    chk("partial_no_write", log_adr.size(), 2);
    chk("partial_busy", {31'd0, busy_o}, 32'd1);
    cfg_wr(2'd3, 32'd1);
    wait_ack("flush");
    chk("busy_during_ack", {31'd0, busy_o}, 32'd1);
    @(negedge clk_i); #2;
    chk("busy_after_ack", {31'd0, busy_o}, 32'd0);
    chk_wr(2, 32'h1008, 32'hFF00_ABA5, 4'b1110);

    // Flush with nothing packed
    nw = log_adr.size();
    cfg_wr(2'd3, 32'd1);
    cfg_rd(2'd3, rd); chk("empty_flush_pending", rd, 32'h5);
    repeat (10) @(negedge clk_i);
    #2;
    chk("empty_flush_no_write", log_adr.size(), nw);
    cfg_rd(2'd3, rd); chk("empty_flush_clear", rd, 32'h0);
    cfg_rd(2'd1, rd); chk("ptr_after_flush", rd, 32'h100C);

    // Stalled write: second word packs, ninth byte waits
    ack_dly = 20;
    a0 = acks;
    for (int i = 0; i < 12; i++) src_q.push_back(8'h10 + 8'(i));
    wait_ack("stall");
    chk("stall_acks_at_first_ack", acks - a0, 8);
    wait_idle("stall");
    chk_wr(3, 32'h100C, 32'h1011_1213, 4'hF);
    chk_wr(4, 32'h1010, 32'h1415_1617, 4'hF);
    chk_wr(5, 32'h1014, 32'h1819_1A1B, 4'hF);

    // Bus error on first word
    ack_dly = 1;
    err_next = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(8'h20 + 8'(i));
    wait_idle("err");
    chk("err_write_count", log_adr.size(), 7);
    chk_wr(6, 32'h101C, 32'h2425_2627, 4'hF);
    cfg_rd(2'd3, rd); chk("err_status", rd, 32'h2);
    cfg_rd(2'd1, rd); chk("ptr_after_err", rd, 32'h1020);
    cfg_wr(2'd3, 32'h2);
    cfg_rd(2'd3, rd); chk("err_cleared", rd, 32'h0);
    cfg_rd(2'd2, rd); chk("total_count", rd, 32'd31);
    cfg_wr(2'd2, 32'hFFFF_FFFF);
    cfg_rd(2'd2, rd); chk("count_cleared", rd, 32'd0);

    // Reset during W_REQ
    ack_dly = 30;
    for (int i = 0; i < 4; i++) src_q.push_back(8'h30 + 8'(i));
    k = 0;
    while (!wb_cyc_o && k < 100) begin @(negedge clk_i); #2; k++; end
    chk("rst_test_cyc_started", {31'd0, wb_cyc_o}, 32'd1);
    @(negedge clk_i); #2;
    src_q.delete();
    rst_i = 1'b1;
    #1;
    chk("midrst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("midrst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("midrst_ack", {31'd0, byte_ack_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    cfg_rd(2'd1, rd); chk("midrst_ptr", rd, 32'd0);
    cfg_rd(2'd2, rd); chk("midrst_cnt", rd, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    chk("post_rst_no_write", log_adr.size(), 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vlx_byte_writer.md
Name: vlx_byte_writer

Overview:
- Downstream stage of the VLX bit-packer datapath in the OR1200 JPEG path.
- Consumes the stuffed byte stream (0xFF is already followed by 0x00 upstream) over a valid/ack byte handshake.
- Packs bytes big-endian into 32-bit words and writes each word to memory as a Wishbone master at an auto-incrementing address.
- Software configures it and flushes partial words through a small SPR-style register port.

Parameters:
- ADDR_W, 32, Wishbone address width.
- FLUSH_FILL, 8'h00, fill byte for unused lanes of a flushed partial word.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- byte_i  in  8  byte from packer; stable while byte_valid_i is high
- byte_valid_i  in  1  packer has a byte (need_send)
- byte_ack_o  out  1  one-cycle pulse: byte taken
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  2  config register select
- cfg_dat_i  in  32  config write data
- cfg_dat_o  out  32  config read data (combinational)
- busy_o  out  1  bytes pending or write in flight
- wb_adr_o  out  ADDR_W  Wishbone address, word aligned
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  byte lane selects
- wb_we_o  out  1  always 1 during a cycle
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_ack_i  in  1  Wishbone ack
- wb_err_i  in  1  Wishbone error

Behaviour:
- Reset (async) values:
  - all outputs 0;
  - pack word 0, byte count 0, holding register empty;
  - pointer 0, total count 0, error flag 0;
  - write FSM in W_IDLE.
- Accept rule:
  - A byte is accepted in a cycle where byte_valid_i=1, byte_ack_o=0, and the pack word has room.
  - byte_ack_o is registered and is 1 in exactly the following cycle.
  - No accept can occur in a cycle where byte_ack_o=1; this gives the packer one cycle to load its next byte.
- Packing (big-endian):
  - Byte k (0..3) goes to bits [31-8k -: 8].
  - The total byte counter (32 bit, wraps) increments on every accept.
- Word hand-off:
  - When the 4th byte is accepted, the word moves to the holding register with sel=4'hF, and the byte count returns to 0.
  - If the holding register is still occupied, the hand-off waits; no further accept occurs until it completes.
  - Packing of the next word overlaps the Wishbone write (double buffer).
- Write FSM:
  - W_IDLE -> W_REQ when the holding register is full.
    - wb_adr_o is latched from the pointer.
    - cyc, stb and we are asserted, with dat/sel driven from the holding register.
  - W_REQ holds until wb_ack_i or wb_err_i.
    - On ack: pointer += 4, holding register freed, -> W_IDLE. cyc/stb deassert the cycle after ack.
    - On err: error flag set (sticky), word dropped, pointer += 4, -> W_IDLE.
  - There is no back-to-back cycle without passing through W_IDLE for 1 clock.
- Flush:
  - Triggered by writing cfg register 3 with bit0=1.
  - If byte count >0, the partial word moves to the holding register once it is free.
    - Unused lanes are FLUSH_FILL.
    - sel has the leading n bits set (n=1 -> 4'b1000, n=2 -> 4'b1100, n=3 -> 4'b1110).
    - The byte count is cleared.
  - If byte count =0, flush is a no-op.
  - A byte accepted in the same cycle as the flush write is included before flushing.
  - The pending flush blocks accepts until it has been handed off.
- Config registers:
  - 0 base: write sets the pointer to {cfg_dat_i[ADDR_W-1:2],2'b00}. A write in flight keeps its latched address.
  - 1 pointer, read-only.
  - 2 total byte count, read-only. Write clears it.
  - 3 control/status:
    - Read: bit0 flush pending, bit1 error, bit2 busy_o.
    - Write: bit0=1 triggers a flush; bit1=1 clears the error flag.
  - Writes to read-only fields are ignored.
- busy_o = (byte count != 0) | holding full | flush pending | wb_cyc_o.
- Reset asserted mid-cycle: cyc/stb drop immediately (async); in-flight data is lost.

Decomposition:
- Shared package vlx_pkg holds:
  - the write-FSM state typedef (W_IDLE, W_REQ);
  - config register index constants (CFG_BASE=0, CFG_PTR=1, CFG_CNT=2, CFG_CTRL=3);
  - the sel-mask function for n leading bytes.
- One natural sub-module: vlx_wb_word_writer, containing the holding register and the Wishbone master FSM.
- The top level keeps the accept/pack logic and the config registers.

Test Plan:
- Base=0x1000; stream 01 02 03 04 05 06 07 08 with wb_ack_i after 2 cycles -> writes 0x01020304 @0x1000, then 0x05060708 @0x1004, sel=F; pointer=0x1008; count=8.
- byte_valid_i held high continuously -> byte_ack_o pulses every other cycle at most, never 2 consecutive cycles; no byte duplicated.
- Stream FF 00 AB, then flush -> one write 0xFF00AB00, sel=4'b1110; busy_o falls 1 cycle after ack; flush with count=0 -> no Wishbone cycle.
- Hold wb_ack_i low for 20 cycles while 8 more bytes arrive -> second word packs, 9th byte not acked until the first write acks; all data in order.
- wb_err_i on the first write -> status bit1=1, pointer advances by 4, next word written normally; writing ctrl bit1 clears it.
- rst_i asserted during W_REQ -> cyc/stb/ack outputs 0 immediately; all registers return to reset values.
